// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the FIFO slave wrapper register map.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] CONTROL  = 4'h0;
    localparam logic [3:0] DATA_IN  = 4'h1;
    localparam logic [3:0] DATA_OUT = 4'h2;
    localparam logic [3:0] STATUS   = 4'h3;

endpackage

// File: rtl/axi_lite_master_cmd.sv
// AXI4-Lite initiator: converts a command/response handshake into single read or write
// transactions, one outstanding at a time, with every output registered.
module axi_lite_master_cmd
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
    parameter int unsigned ERR_CNT_WIDTH      = 8
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_aresetn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              busy,
    output logic [ERR_CNT_WIDTH-1:0]          err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StResp
    } state_e;

    state_e                            r_state, w_state_nxt;
    logic                              r_cmd_ready, w_cmd_ready_nxt;
    logic                              r_busy, w_busy_nxt;
    logic                              r_rsp_valid, w_rsp_valid_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]                        r_rsp_resp, w_rsp_resp_nxt;
    logic [ERR_CNT_WIDTH-1:0]          r_err_count, w_err_count_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr, w_addr_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata, w_wdata_nxt;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb, w_wstrb_nxt;
    logic                              r_awvalid, w_awvalid_nxt;
    logic                              r_wvalid, w_wvalid_nxt;
    logic                              r_aw_done, w_aw_done_nxt;
    logic                              r_w_done, w_w_done_nxt;
    logic                              r_bready, w_bready_nxt;
    logic                              r_arvalid, w_arvalid_nxt;
    logic                              r_rready, w_rready_nxt;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state     <= StIdle;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
            r_err_count <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            r_err_count <= w_err_count_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_err_count_nxt = r_err_count;

        unique case (r_state)
            StIdle: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_addr_nxt      = cmd_addr;
                    w_wdata_nxt     = cmd_wdata;
                    w_wstrb_nxt     = cmd_wstrb;
                    w_aw_done_nxt   = 1'b0;
                    w_w_done_nxt    = 1'b0;
                    if (cmd_write) begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = StWrAddrData;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = StRdAddr;
                    end
                end
            end
            StWrAddrData: begin
                // AW and W complete independently; B is only accepted once both are done
                if (r_awvalid && m_axi_awready) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (r_wvalid && m_axi_wready) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = StWrResp;
                end
            end
            StWrResp: begin
                if (r_bready && m_axi_bvalid) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = m_axi_bresp;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = StResp;
                end
            end
            StRdAddr: begin
                if (r_arvalid && m_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = StRdData;
                end
            end
            StRdData: begin
                if (r_rready && m_axi_rvalid) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_rdata_nxt = m_axi_rdata;
                    w_rsp_resp_nxt  = m_axi_rresp;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        w_busy_nxt = (w_state_nxt != StIdle);

        if ((w_state_nxt == StResp) && (r_state != StResp) && (w_rsp_resp_nxt != RESP_OKAY) &&
            (r_err_count != {ERR_CNT_WIDTH{1'b1}})) begin
            w_err_count_nxt = r_err_count + 1'b1;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign err_count     = r_err_count;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Directed + randomized bench for axi_lite_master_cmd against a behavioural AXI responder
// with a register-array memory and a separate reference memory / error-count model.
module tb_axi_lite_master_cmd;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [3:0]  cmd_addr = '0, cmd_wstrb = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_count;
    logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [31:0] m_axi_wdata;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic [31:0] m_axi_rdata = '0;

    always #5 clk = ~clk;

    axi_lite_master_cmd #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (4),
        .ERR_CNT_WIDTH      (8)
    ) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .busy          (busy),
        .err_count     (err_count),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- responder: readies after programmable delays, memory of 16 words
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
    logic [31:0] s_mem [16];
    logic        hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;
    logic [3:0]  s_awaddr = '0, s_araddr = '0, s_wstrb = '0;
    logic [31:0] s_wdata = '0;
    logic        got_aw = 0, got_w = 0, got_ar = 0;

    always @(posedge clk) begin
        hs_aw <= m_axi_awvalid && m_axi_awready;
        hs_w  <= m_axi_wvalid && m_axi_wready;
        hs_b  <= m_axi_bvalid && m_axi_bready;
        hs_ar <= m_axi_arvalid && m_axi_arready;
        hs_r  <= m_axi_rvalid && m_axi_rready;
        if (m_axi_awvalid && m_axi_awready) s_awaddr <= m_axi_awaddr;
        if (m_axi_wvalid && m_axi_wready) begin
            s_wdata <= m_axi_wdata;
            s_wstrb <= m_axi_wstrb;
        end
        if (m_axi_arvalid && m_axi_arready) s_araddr <= m_axi_araddr;
    end

    initial begin
        int aw_cnt, w_cnt, ar_cnt;
        for (int i = 0; i < 16; i++) s_mem[i] = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                got_aw = 0; got_w = 0; got_ar = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (hs_aw) begin
                    m_axi_awready = 0; got_aw = 1; aw_cnt = 0;
                end else if (m_axi_awvalid && !m_axi_awready && !got_aw) begin
                    if (aw_cnt >= aw_delay) m_axi_awready = 1; else aw_cnt++;
                end
                if (hs_w) begin
                    m_axi_wready = 0; got_w = 1; w_cnt = 0;
                end else if (m_axi_wvalid && !m_axi_wready && !got_w) begin
                    if (w_cnt >= w_delay) m_axi_wready = 1; else w_cnt++;
                end
                if (hs_b) begin
                    m_axi_bvalid = 0; got_aw = 0; got_w = 0;
                end else if (got_aw && got_w && !m_axi_bvalid) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) s_mem[s_awaddr][8*b +: 8] = s_wdata[8*b +: 8];
                    m_axi_bresp  = cfg_bresp;
                    m_axi_bvalid = 1;
                end
                if (hs_ar) begin
                    m_axi_arready = 0; got_ar = 1; ar_cnt = 0;
                end else if (m_axi_arvalid && !m_axi_arready && !got_ar) begin
                    if (ar_cnt >= ar_delay) m_axi_arready = 1; else ar_cnt++;
                end
                if (hs_r) begin
                    m_axi_rvalid = 0; got_ar = 0;
                end else if (got_ar && !m_axi_rvalid) begin
                    m_axi_rdata  = s_mem[s_araddr];
                    m_axi_rresp  = cfg_rresp;
                    m_axi_rvalid = 1;
                end
            end
        end
    end

    // ---------------- protocol monitor: valid persistence, payload stability, ordering
    int          viol = 0;
    logic        p_rst = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic        p_rv = 0, p_rr = 0;
    logic [3:0]  p_awaddr = '0, p_araddr = '0;
    logic [31:0] p_wdata = '0, p_rdata = '0;
    logic [1:0]  p_resp = '0;

    always @(posedge clk) begin
        if (rst_n && p_rst) begin
            if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) viol <= viol + 1;
            if (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata !== p_wdata)) viol <= viol + 1;
            if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) viol <= viol + 1;
            if (p_rv && !p_rr && (!rsp_valid || rsp_rdata !== p_rdata || rsp_resp !== p_resp))
                viol <= viol + 1;
            if (m_axi_bready && !(got_aw && got_w)) viol <= viol + 1;
            if (m_axi_rready && !got_ar) viol <= viol + 1;
            if (rsp_valid && cmd_ready) viol <= viol + 1;
        end
        p_rst <= rst_n;
        p_awv <= m_axi_awvalid; p_awr <= m_axi_awready; p_awaddr <= m_axi_awaddr;
        p_wv  <= m_axi_wvalid;  p_wr  <= m_axi_wready;  p_wdata  <= m_axi_wdata;
        p_arv <= m_axi_arvalid; p_arr <= m_axi_arready; p_araddr <= m_axi_araddr;
        p_rv  <= rsp_valid;     p_rr  <= rsp_ready;     p_rdata  <= rsp_rdata;
        p_resp <= rsp_resp;
    end

    // ---------------- reference model
    logic [31:0] ref_mem [16];
    int          exp_err = 0;
    int          acc_cyc = 0;
    logic        q_wr;
    logic [3:0]  q_addr, q_strb;
    logic [31:0] q_data;

    task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        q_wr = wr; q_addr = a; q_data = d; q_strb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("cmd_accept", cmd_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        cmd_valid = 0;
        check("cmd_ready_drop", cmd_ready, 0);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic finish_rsp(input int rdy_delay);
        int          n;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("rsp_valid", rsp_valid, 1);
        check("min_latency", (cyc - acc_cyc) >= 2, 1);
        if (q_wr) begin
            exp_rdata = '0;
            exp_resp  = cfg_bresp;
            for (int b = 0; b < 4; b++)
                if (q_strb[b]) ref_mem[q_addr][8*b +: 8] = q_data[8*b +: 8];
        end else begin
            exp_rdata = ref_mem[q_addr];
            exp_resp  = cfg_rresp;
        end
        if (exp_resp != RESP_OKAY && exp_err < 255) exp_err++;
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_resp", rsp_resp, exp_resp);
        check("err_count", err_count, exp_err);
        check("cmd_ready_in_rsp", cmd_ready, 0);
        repeat (rdy_delay) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("busy_after_rsp", busy, 0);
        check("cmd_ready_after_rsp", cmd_ready, 1);
    endtask

    initial begin
        logic        wr, stale;
        logic [3:0]  a, s;
        logic [31:0] d, hold_rdata;
        logic [1:0]  hold_resp;
        int          n, hs_cyc;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err_count", err_count, 0);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check("rst_readies", {m_axi_bready, m_axi_rready}, 0);
        check("rst_addr_data", {m_axi_awaddr, m_axi_wdata, rsp_rdata, rsp_resp}, 0);
        rst_n = 1;
        check("cmd_ready_at_release", cmd_ready, 0);
        @(posedge clk); #1;
        check("cmd_ready_after_release", cmd_ready, 1);

        // register writes then readback
        send_cmd(1, CONTROL, 32'h1, 4'hF);
        finish_rsp(0);
        send_cmd(1, DATA_IN, 32'h5, 4'hF);
        finish_rsp(1);
        check("slave_control", s_mem[CONTROL], 32'h1);
        check("slave_data_in", s_mem[DATA_IN], 32'h5);
        send_cmd(0, DATA_IN, 32'h0, 4'h0);
        finish_rsp(0);

        // awready delayed by 3, wready immediate
        aw_delay = 3;
        send_cmd(1, DATA_OUT, 32'hCAFE_0042, 4'hF);
        @(posedge clk); #1;
        check("t3_wvalid_dropped", m_axi_wvalid, 0);
        check("t3_awvalid_held", m_axi_awvalid, 1);
        check("t3_bready_low", m_axi_bready, 0);
        @(posedge clk); #1;
        check("t3_awaddr_stable", {m_axi_awvalid, m_axi_awaddr}, {1'b1, DATA_OUT});
        check("t3_bready_still_low", m_axi_bready, 0);
        finish_rsp(0);
        aw_delay = 0;

        // randomized traffic with OKAY responses
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3);
            send_cmd(wr, a, d, s);
            finish_rsp($urandom_range(0, 2));
        end

        // error responses pass through; counter saturates
        cfg_rresp = RESP_SLVERR;
        cfg_bresp = RESP_DECERR;
        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = $urandom;
            aw_delay = $urandom_range(0, 1);
            w_delay  = $urandom_range(0, 1);
            ar_delay = $urandom_range(0, 1);
            send_cmd(wr, a, d, 4'hF);
            finish_rsp(0);
        end
        check("err_saturated", err_count, 8'hFF);
        cfg_rresp = RESP_OKAY;
        cfg_bresp = RESP_OKAY;
        aw_delay = 0; w_delay = 0; ar_delay = 0;

        // back-pressure on the response with a command waiting
        send_cmd(0, DATA_IN, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("t5_rsp_valid", rsp_valid, 1);
        cmd_valid = 1; cmd_write = 1; cmd_addr = STATUS; cmd_wdata = 32'hA5A5_0003; cmd_wstrb = 4'hF;
        hold_rdata = rsp_rdata;
        hold_resp  = rsp_resp;
        repeat (5) begin
            @(posedge clk); #1;
            check("t5_hold_valid", rsp_valid, 1);
            check("t5_hold_rsp", {rsp_rdata, rsp_resp}, {hold_rdata, hold_resp});
            check("t5_no_accept", cmd_ready, 0);
            check("t5_no_axi_valid", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        end
        finish_rsp(0);
        hs_cyc = cyc;
        send_cmd(1, STATUS, 32'hA5A5_0003, 4'hF);
        check("t5_accept_delay", acc_cyc - hs_cyc, 1);
        finish_rsp(0);

        // reset while awvalid is pending
        aw_delay = 5;
        send_cmd(1, DATA_OUT, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk); #1;
        check("t6_awvalid_before", m_axi_awvalid, 1);
        #2;
        rst_n = 0;
        #1;
        check("t6_valids_cleared", {m_axi_awvalid, m_axi_wvalid, rsp_valid}, 0);
        check("t6_others_cleared", {m_axi_bready, cmd_ready, busy}, 0);
        aw_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        check("t6_cmd_ready_after", cmd_ready, 1);
        stale = 0;
        repeat (10) begin
            @(posedge clk); #1;
            stale = stale | rsp_valid | busy;
        end
        check("t6_no_stale_rsp", stale, 0);
        check("t6_err_cleared", err_count, 0);
        exp_err = 0;
        send_cmd(0, DATA_OUT, 32'h0, 4'h0);
        finish_rsp(0);

        check("protocol_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
